// File: rtl/dummy_pkg.sv
// Shared types and default constants for the dummy signature collector.
package dummy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } coll_state_t;

  localparam logic [15:0] DEF_POLY = 16'h002D;
  localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/dummy_misr_step.sv
// One MISR step: shift left, fold in POLY when the MSB falls out, XOR the new bit into bit 0.
module dummy_misr_step #(
  parameter int unsigned           SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0]  POLY      = SIG_WIDTH'(16'h002D)
) (
  input  logic [SIG_WIDTH-1:0] sig_in,
  input  logic                 bit_in,
  output logic [SIG_WIDTH-1:0] sig_out
);

  // Next-signature function.
  always_comb begin
    sig_out = {sig_in[SIG_WIDTH-2:0], 1'b0}
            ^ (sig_in[SIG_WIDTH-1] ? POLY : {SIG_WIDTH{1'b0}})
            ^ {{(SIG_WIDTH-1){1'b0}}, bit_in};
  end

endmodule

// File: rtl/dummy_sig_collector.sv
// Samples the filler chain output for WINDOW cycles after a start, compresses it
// into a MISR signature plus a ones count, and offers the result on valid/ready.
module dummy_sig_collector
  import dummy_pkg::*;
#(
  parameter int unsigned          SIG_WIDTH = 16,
  parameter int unsigned          WINDOW    = 256,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEF_POLY),
  parameter logic [SIG_WIDTH-1:0] SEED      = SIG_WIDTH'(DEF_SEED),
  localparam int unsigned         CNT_W     = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 in_i,
  output logic                 busy_o,
  output logic                 sig_valid_o,
  input  logic                 sig_ready_i,
  output logic [SIG_WIDTH-1:0] sig_data_o,
  output logic [CNT_W-1:0]     ones_cnt_o,
  output logic                 overrun_o
);

  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WINDOW - 1);

  coll_state_t          state_q;
  logic [SIG_WIDTH-1:0] sig_q;
  logic [SIG_WIDTH-1:0] sig_d;
  logic [CNT_W-1:0]     ones_q;
  logic [CNT_W-1:0]     smp_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 ovr_q;

  dummy_misr_step #(
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY)
  ) u_step (
    .sig_in  (sig_q),
    .bit_in  (in_i),
    .sig_out (sig_d)
  );

  // Collection FSM with registered handshake, counters and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      ones_q  <= '0;
      smp_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= COLLECT;
            sig_q   <= SEED;
            ones_q  <= '0;
            smp_q   <= '0;
            busy_q  <= 1'b1;
            ovr_q   <= 1'b0;
          end
        end
        COLLECT: begin
          sig_q  <= sig_d;
          ones_q <= ones_q + CNT_W'(in_i);
          smp_q  <= smp_q + CNT_W'(1);
          if (start_i) ovr_q <= 1'b1;
          if (smp_q == LAST_SMP) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (sig_ready_i) begin
            valid_q <= 1'b0;
            if (start_i) begin
              // Result consumed and a new window seeded on the same edge.
              state_q <= COLLECT;
              sig_q   <= SEED;
              ones_q  <= '0;
              smp_q   <= '0;
              busy_q  <= 1'b1;
              ovr_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (start_i) begin
            ovr_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign sig_valid_o = valid_q;
  assign sig_data_o  = sig_q;
  assign ones_cnt_o  = ones_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_dummy_sig_collector.sv
// Self-checking bench for dummy_sig_collector (8-bit MISR, POLY 8'h1D, SEED 0).
module tb_dummy_sig_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, din, ready;
  logic       busy, valid, ovr;
  logic [7:0] sdata;
  logic [2:0] ones;
  logic       start16, din16, ready16;
  logic       busy16, valid16, ovr16;
  logic [7:0] sdata16;
  logic [4:0] ones16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_sig_q[$];
  int         exp_ones_q[$];

  always #5 clk = ~clk;

  dummy_sig_collector #(
    .SIG_WIDTH (8), .WINDOW (4), .POLY (8'h1D), .SEED (8'h00)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .start_i (start), .in_i (din),
    .busy_o (busy), .sig_valid_o (valid), .sig_ready_i (ready),
    .sig_data_o (sdata), .ones_cnt_o (ones), .overrun_o (ovr)
  );

  dummy_sig_collector #(
    .SIG_WIDTH (8), .WINDOW (16), .POLY (8'h1D), .SEED (8'h00)
  ) u_dut16 (
    .clk (clk), .rst_n (rst_n), .start_i (start16), .in_i (din16),
    .busy_o (busy16), .sig_valid_o (valid16), .sig_ready_i (ready16),
    .sig_data_o (sdata16), .ones_cnt_o (ones16), .overrun_o (ovr16)
  );

  function automatic logic [7:0] misr8(input logic [7:0] s, input logic b);
    logic [7:0] r;
    r = {s[6:0], 1'b0};
    if (s[7]) r = r ^ 8'h1D;
    r[0] = r[0] ^ b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one 4-sample window (optionally its start) and pushes the expected result.
  task automatic feed_window(input logic [3:0] bits, input int pulse_k, input logic do_start);
    logic [7:0] s;
    int         o;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    s = 8'h00;
    o = 0;
    for (int k = 0; k < 4; k++) begin
      din   = bits[k];
      start = (k == pulse_k);
      s     = misr8(s, bits[k]);
      o     = o + int'(bits[k]);
      tick();
    end
    start = 1'b0;
    exp_sig_q.push_back(s);
    exp_ones_q.push_back(o);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; din = 0; ready = 0; start16 = 0; din16 = 0; ready16 = 0;
    tick();
    n_cmp++;
    if ({busy, valid, sdata, ones, ovr} !== 14'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {busy, valid, sdata, ones, ovr});
    end
    n_cmp++;
    if ({busy16, valid16, sdata16, ones16, ovr16} !== 16'd0) begin
      n_bad++; $display("FAIL reset_outputs16: got %h want 0", {busy16, valid16, sdata16, ones16, ovr16});
    end
    rst_n = 1'b1;
    tick();
    start = 1'b1; din = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_before_reset: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, valid, sdata, ones, ovr} !== 14'd0) begin
      n_bad++; $display("FAIL reset_mid_collect: got %h want 0", {busy, valid, sdata, ones, ovr});
    end
    tick();
    rst_n = 1'b1; din = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({busy, valid, sdata, ones} !== 13'd0) begin
      n_bad++; $display("FAIL idle_after_reset: got %h want 0", {busy, valid, sdata, ones});
    end
  endtask

  task automatic test_ones();
    logic [7:0] es;
    int         eo;
    start = 1'b1; din = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_bad++; $display("FAIL ones_e0: busy=%b valid=%b want 1/0", busy, valid);
    end
    feed_window(4'b1111, -1, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ones_latency: valid=%b busy=%b want 1/0", valid, busy);
    end
    es = exp_sig_q.pop_front();
    eo = exp_ones_q.pop_front();
    n_cmp++;
    if (sdata !== es || sdata !== 8'h0F) begin
      n_bad++; $display("FAIL ones_sig: got %h want %h/0f", sdata, es);
    end
    n_cmp++;
    if (int'(ones) !== eo || ones !== 3'd4) begin
      n_bad++; $display("FAIL ones_cnt: got %0d want %0d", ones, eo);
    end
    tick();
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b0 || sdata !== es) begin
      n_bad++; $display("FAIL ones_handshake: valid=%b busy=%b sig=%h want 0/0/%h", valid, busy, sdata, es);
    end
  endtask

  task automatic test_zero_hold();
    logic [7:0] es;
    int         eo;
    ready = 1'b0;
    feed_window(4'b0000, -1, 1'b1);
    es = exp_sig_q.pop_front();
    eo = exp_ones_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || sdata !== 8'h00 || sdata !== es || int'(ones) !== eo) begin
      n_bad++; $display("FAIL zero_result: valid=%b sig=%h ones=%0d want 1/%h/%0d", valid, sdata, ones, es, eo);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b1 || sdata !== es || int'(ones) !== eo) begin
        n_bad++; $display("FAIL hold_stable c=%0d: valid=%b sig=%h ones=%0d want 1/%h/%0d", c, valid, sdata, ones, es, eo);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL zero_release: valid=%b want 0", valid); end
  endtask

  task automatic test_window16();
    logic [7:0] s;
    start16 = 1'b1; din16 = 1'b1;
    tick();
    start16 = 1'b0;
    s = 8'h00;
    for (int k = 0; k < 9; k++) begin
      s = misr8(s, 1'b1);
      tick();
    end
    n_cmp++;
    if (sdata16 !== 8'hE2 || sdata16 !== s || busy16 !== 1'b1 || valid16 !== 1'b0) begin
      n_bad++; $display("FAIL w16_nine: sig=%h busy=%b valid=%b want e2/1/0", sdata16, busy16, valid16);
    end
    for (int k = 9; k < 16; k++) begin
      s = misr8(s, 1'b1);
      tick();
    end
    n_cmp++;
    if (valid16 !== 1'b1 || ones16 !== 5'd16 || sdata16 !== s) begin
      n_bad++; $display("FAIL w16_final: valid=%b ones=%0d sig=%h want 1/16/%h", valid16, ones16, sdata16, s);
    end
    ready16 = 1'b1;
    tick();
    ready16 = 1'b0;
    n_cmp++;
    if (valid16 !== 1'b0) begin n_bad++; $display("FAIL w16_release: valid=%b want 0", valid16); end
  endtask

  task automatic test_overrun();
    logic [7:0] es;
    int         eo;
    logic [3:0] b;
    b = 4'($urandom);
    feed_window(b, 1, 1'b1);
    es = exp_sig_q.pop_front();
    eo = exp_ones_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || sdata !== es || int'(ones) !== eo) begin
      n_bad++; $display("FAIL ovr_result: valid=%b sig=%h ones=%0d want 1/%h/%0d", valid, sdata, ones, es, eo);
    end
    n_cmp++;
    if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_collect: got %b want 1", ovr); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (valid !== 1'b1 || busy !== 1'b0 || sdata !== es || ovr !== 1'b1) begin
      n_bad++; $display("FAIL ovr_hold_start: valid=%b busy=%b sig=%h ovr=%b want 1/0/%h/1", valid, busy, sdata, ovr, es);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || ovr !== 1'b1) begin
      n_bad++; $display("FAIL ovr_sticky: valid=%b ovr=%b want 0/1", valid, ovr);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (ovr !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL ovr_clear: ovr=%b busy=%b want 0/1", ovr, busy);
    end
    b = 4'($urandom);
    feed_window(b, -1, 1'b0);
    es = exp_sig_q.pop_front();
    eo = exp_ones_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || sdata !== es || int'(ones) !== eo || ovr !== 1'b0) begin
      n_bad++; $display("FAIL ovr_next: valid=%b sig=%h ones=%0d ovr=%b want 1/%h/%0d/0", valid, sdata, ones, ovr, es, eo);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] es;
    int         eo;
    feed_window(4'b1011, -1, 1'b1);
    es = exp_sig_q.pop_front();
    eo = exp_ones_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || sdata !== es || int'(ones) !== eo) begin
      n_bad++; $display("FAIL b2b_first: valid=%b sig=%h ones=%0d want 1/%h/%0d", valid, sdata, ones, es, eo);
    end
    ready = 1'b1; start = 1'b1;
    tick();
    ready = 1'b0; start = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b1 || ovr !== 1'b0) begin
      n_bad++; $display("FAIL b2b_restart: valid=%b busy=%b ovr=%b want 0/1/0", valid, busy, ovr);
    end
    feed_window(4'b0110, -1, 1'b0);
    es = exp_sig_q.pop_front();
    eo = exp_ones_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || sdata !== es || int'(ones) !== eo || ovr !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second: valid=%b sig=%h ones=%0d ovr=%b want 1/%h/%0d/0", valid, sdata, ones, ovr, es, eo);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_release: valid=%b busy=%b want 0/0", valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_zero_hold();
    test_window16();
    test_overrun();
    test_back_to_back();
    n_cmp++;
    if (exp_sig_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_sig_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
